// File: rtl/daisy_lf_pkg.sv
// Shared definitions for the daisy digital loop filter: FSM state encoding
// and the default widths, gains and clamp limits used as parameter defaults.
package daisy_lf_pkg;

    typedef enum logic [0:0] {
        LF_IDLE = 1'b0,
        LF_MEAS = 1'b1
    } lf_state_e;

    localparam int LF_CNT_W     = 8;
    localparam int LF_ACC_W     = 16;
    localparam int LF_OUT_W     = 8;
    localparam int LF_KP_SHIFT  = 2;
    localparam int LF_KI_SHIFT  = 4;
    localparam int LF_CTRL_INIT = 128;
    localparam int LF_CTRL_MIN  = 3;
    localparam int LF_CTRL_MAX  = 252;

endpackage

// File: rtl/daisy_lf_pwm.sv
// PWM generator for the loop filter control word. Only present when the
// DAISY_LF_PWM_EN macro is defined; without it this file declares nothing.
`ifdef DAISY_LF_PWM_EN
module daisy_lf_pwm
    import daisy_lf_pkg::*;
#(
    parameter int OUT_W = LF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OUT_W-1:0] duty_in,
    output logic             out
);

    logic [OUT_W-1:0] pwm_cnt;
    logic [OUT_W-1:0] duty;

    // Free-running period counter; duty is only resampled at the wrap so a
    // control update never produces a runt pulse mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (&pwm_cnt) begin
                duty <= duty_in;
            end
        end
    end

    assign out = (pwm_cnt < duty);

endmodule
`endif

// File: rtl/daisy_digital_loop_filter.sv
// Digital PI loop filter driven by PFD up/down pulses. Each up rising edge
// closes a measurement period; the up/down pulse widths of that period feed
// a proportional + integral update of the control word two cycles later.
// Optional PWM output is enabled by defining DAISY_LF_PWM_EN.
module daisy_digital_loop_filter
    import daisy_lf_pkg::*;
#(
    parameter int CNT_W     = LF_CNT_W,
    parameter int ACC_W     = LF_ACC_W,
    parameter int OUT_W     = LF_OUT_W,
    parameter int KP_SHIFT  = LF_KP_SHIFT,
    parameter int KI_SHIFT  = LF_KI_SHIFT,
    parameter int CTRL_INIT = LF_CTRL_INIT,
    parameter int CTRL_MIN  = LF_CTRL_MIN,
    parameter int CTRL_MAX  = LF_CTRL_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             dwn,
    output logic [OUT_W-1:0] ctrl,
    output logic             ctrl_vld,
    output logic             sat,
    output logic             out
);

    localparam int ERR_W  = CNT_W + 1;
    localparam int SUM_W  = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;
    localparam int PI_A_W = (ACC_W > ERR_W + KP_SHIFT) ? ACC_W : ERR_W + KP_SHIFT;
    localparam int PI_W   = ((PI_A_W > OUT_W + 1) ? PI_A_W : OUT_W + 1) + 3;

    localparam logic signed [SUM_W-1:0] ACC_MAX_S = SUM_W'({1'b0, {(ACC_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] ACC_MIN_S = ~ACC_MAX_S;
    localparam logic signed [PI_W-1:0]  C_INIT    = PI_W'(CTRL_INIT);
    localparam logic signed [PI_W-1:0]  C_MIN     = PI_W'(CTRL_MIN);
    localparam logic signed [PI_W-1:0]  C_MAX     = PI_W'(CTRL_MAX);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (v > ACC_MAX_S) begin
            return ACC_MAX_S[ACC_W-1:0];
        end else if (v < ACC_MIN_S) begin
            return ACC_MIN_S[ACC_W-1:0];
        end
        return v[ACC_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] clamp_ctrl(input logic signed [PI_W-1:0] v);
        if (v < C_MIN) begin
            return C_MIN[OUT_W-1:0];
        end else if (v > C_MAX) begin
            return C_MAX[OUT_W-1:0];
        end
        return v[OUT_W-1:0];
    endfunction

    lf_state_e               state;
    logic                    up_q;
    logic                    rise;
    logic [CNT_W-1:0]        cnt_up;
    logic [CNT_W-1:0]        cnt_dwn;
    logic [CNT_W-1:0]        cnt_up_s;
    logic [CNT_W-1:0]        cnt_dwn_s;
    logic                    vld_p0;

    logic signed [ERR_W-1:0] err_c;
    logic signed [SUM_W-1:0] acc_sum;
    logic                    acc_clip_c;
    logic signed [ERR_W-1:0] err_p1;
    logic signed [ACC_W-1:0] acc;
    logic                    acc_clip_p1;
    logic                    vld_p1;

    logic signed [ACC_W-1:0] acc_shr;
    logic signed [PI_W-1:0]  err_w;
    logic signed [PI_W-1:0]  pi_sum;
    logic                    ctrl_clip;

    assign rise = up & ~up_q;

    // Edge detection, FSM and period counters; a rising edge in MEAS
    // snapshots the finished period and restarts counting with this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LF_IDLE;
            up_q      <= 1'b0;
            cnt_up    <= '0;
            cnt_dwn   <= '0;
            cnt_up_s  <= '0;
            cnt_dwn_s <= '0;
            vld_p0    <= 1'b0;
        end else begin
            up_q   <= up;
            vld_p0 <= 1'b0;
            if (!en) begin
                state     <= LF_IDLE;
                cnt_up    <= '0;
                cnt_dwn   <= '0;
                cnt_up_s  <= '0;
                cnt_dwn_s <= '0;
            end else if (state == LF_IDLE) begin
                if (rise) begin
                    state   <= LF_MEAS;
                    cnt_up  <= CNT_W'(1);
                    cnt_dwn <= CNT_W'(dwn);
                end
            end else if (rise) begin
                cnt_up_s  <= cnt_up;
                cnt_dwn_s <= cnt_dwn;
                vld_p0    <= 1'b1;
                cnt_up    <= CNT_W'(1);
                cnt_dwn   <= CNT_W'(dwn);
            end else begin
                if (up) begin
                    cnt_up <= sat_inc(cnt_up);
                end
                if (dwn) begin
                    cnt_dwn <= sat_inc(cnt_dwn);
                end
            end
        end
    end

    // ---- stage p0 -> p1: phase error and integrator ----
    assign err_c      = $signed({1'b0, cnt_up_s}) - $signed({1'b0, cnt_dwn_s});
    assign acc_sum    = SUM_W'(acc) + SUM_W'(err_c);
    assign acc_clip_c = (acc_sum > ACC_MAX_S) || (acc_sum < ACC_MIN_S);

    // Error register and saturating integrator; disabling drops the update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_p1      <= '0;
            acc         <= '0;
            acc_clip_p1 <= 1'b0;
            vld_p1      <= 1'b0;
        end else if (!en) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                err_p1      <= err_c;
                acc         <= sat_acc(acc_sum);
                acc_clip_p1 <= acc_clip_c;
            end
        end
    end

    // ---- stage p1 -> p2: PI sum and output clamp ----
    // acc here is already the integrator value produced for this update.
    assign acc_shr   = acc >>> KI_SHIFT;
    assign err_w     = PI_W'(err_p1);
    assign pi_sum    = C_INIT + (err_w <<< KP_SHIFT) + PI_W'(acc_shr);
    assign ctrl_clip = (pi_sum < C_MIN) || (pi_sum > C_MAX);

    // Control word, update strobe and clamp flag; held while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= OUT_W'(CTRL_INIT);
            ctrl_vld <= 1'b0;
            sat      <= 1'b0;
        end else if (!en) begin
            ctrl_vld <= 1'b0;
        end else begin
            ctrl_vld <= vld_p1;
            if (vld_p1) begin
                ctrl <= clamp_ctrl(pi_sum);
                sat  <= acc_clip_p1 | ctrl_clip;
            end
        end
    end

`ifdef DAISY_LF_PWM_EN
    daisy_lf_pwm #(
        .OUT_W(OUT_W)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .duty_in(ctrl),
        .out    (out)
    );
`else
    assign out = 1'b0;
`endif

endmodule

// File: tb/tb_daisy_digital_loop_filter.sv
// Self-checking bench for daisy_digital_loop_filter: directed scenarios plus
// randomized PFD pulse trains compared against a period-level PI model.
module tb_daisy_digital_loop_filter;

    localparam int CMAX   = 255;
    localparam int AMAX   = 32767;
    localparam int AMIN   = -32768;
    localparam int CINIT  = 128;
    localparam int CLO    = 3;
    localparam int CHI    = 252;
`ifdef DAISY_LF_PWM_EN
    localparam int PWM_EXP = 64;
`else
    localparam int PWM_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       up  = 1'b0;
    logic       dwn = 1'b0;
    logic [7:0] ctrl;
    logic       ctrl_vld;
    logic       sat;
    logic       out;

    daisy_digital_loop_filter dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .dwn     (dwn),
        .ctrl    (ctrl),
        .ctrl_vld(ctrl_vld),
        .sat     (sat),
        .out     (out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: one entry per completed measurement period.
    typedef struct {
        int err;
        int t0;
        int acc_v;
        bit acc_clip;
    } ent_t;

    ent_t mq[$];
    int   cyc = 0;
    bit   m_prev, m_meas, m_sat, exp_vld;
    int   m_cu, m_cd, m_acc, m_ctrl;
    int   log_ctrl[$];
    int   log_sat[$];
    int   high_cnt = 0;

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic m_reset();
        m_prev = 0; m_meas = 0; m_cu = 0; m_cd = 0;
        m_acc = 0; m_ctrl = CINIT; m_sat = 0; exp_vld = 0;
        mq.delete();
    endtask

    task automatic model_edge(input bit e, input bit u, input bit d);
        bit   rise;
        ent_t ent;
        int   v;
        bit   clip;
        rise    = u && !m_prev;
        m_prev  = u;
        exp_vld = 0;
        if (!e) begin
            m_meas = 0; m_cu = 0; m_cd = 0;
            mq.delete();
        end else begin
            // control update for the period closed two cycles ago
            if (mq.size() > 0 && mq[0].t0 == cyc - 2) begin
                ent  = mq.pop_front();
                v    = CINIT + ent.err * 4 + floor_div(ent.acc_v, 16);
                clip = (v < CLO) || (v > CHI);
                m_ctrl  = (v < CLO) ? CLO : (v > CHI) ? CHI : v;
                m_sat   = clip || ent.acc_clip;
                exp_vld = 1;
            end
            // integrator update for the period closed last cycle
            if (mq.size() > 0 && mq[0].t0 == cyc - 1) begin
                ent  = mq[0];
                v    = m_acc + ent.err;
                ent.acc_clip = (v > AMAX) || (v < AMIN);
                m_acc = (v > AMAX) ? AMAX : (v < AMIN) ? AMIN : v;
                ent.acc_v = m_acc;
                mq[0] = ent;
            end
            if (!m_meas) begin
                if (rise) begin
                    m_meas = 1; m_cu = 1; m_cd = d;
                end
            end else if (rise) begin
                ent.err = m_cu - m_cd;
                ent.t0 = cyc;
                ent.acc_v = 0;
                ent.acc_clip = 0;
                mq.push_back(ent);
                m_cu = 1; m_cd = d;
            end else begin
                if (u && m_cu < CMAX) m_cu++;
                if (d && m_cd < CMAX) m_cd++;
            end
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare 1 time unit later.
    task automatic step(input bit e, input bit u, input bit d);
        en = e; up = u; dwn = d;
        @(posedge clk);
        cyc++;
        model_edge(e, u, d);
        #1;
        check("ctrl_vld", ctrl_vld, exp_vld);
        check("ctrl", ctrl, m_ctrl);
        check("sat", sat, m_sat);
`ifndef DAISY_LF_PWM_EN
        check("out_tied", out, 0);
`endif
        if (ctrl_vld) begin
            log_ctrl.push_back(ctrl);
            log_sat.push_back(sat);
        end
        if (out) high_cnt++;
        @(negedge clk);
    endtask

    task automatic period(input int uw, input int dw, input int len);
        for (int i = 0; i < len; i++) step(1'b1, i < uw, i < dw);
    endtask

    // Asynchronous reset pulse starting between clock edges.
    task automatic do_reset();
        up = 0; dwn = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_ctrl", ctrl, CINIT);
        check("rst_vld", ctrl_vld, 0);
        check("rst_sat", sat, 0);
        check("rst_out", out, 0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_log();
        log_ctrl.delete();
        log_sat.delete();
    endtask

    initial begin
        int ur, dr;
        bit uv, dv, ev;
        m_reset();
        @(negedge clk);
        do_reset();

        // Three periods of up=10 / dwn=4, explicit latency on the last edge
        clear_log();
        repeat (3) period(10, 4, 50);
        step(1, 1, 1); check("lat_e0", ctrl_vld, 0);
        step(1, 1, 1); check("lat_e1", ctrl_vld, 0);
        step(1, 1, 1); check("lat_e2", ctrl_vld, 1);
        for (int i = 3; i < 50; i++) step(1'b1, i < 10, i < 4);
        check("p3_n", log_ctrl.size(), 3);
        check("p3_u0", log_ctrl[0], 152);
        check("p3_u1", log_ctrl[1], 152);
        check("p3_u2", log_ctrl[2], 153);

        // Balanced pulses keep the loop at its initial point
        do_reset();
        clear_log();
        repeat (11) period(7, 7, 10);
        check("bal_n", log_ctrl.size(), 10);
        foreach (log_ctrl[i]) begin
            check("bal_ctrl", log_ctrl[i], 128);
            check("bal_sat", log_sat[i], 0);
        end

        // Long down pulse -> low clamp; long up pulse -> counter saturation
        do_reset();
        clear_log();
        step(1, 1, 0);
        step(1, 0, 0);
        repeat (201) step(1, 0, 1);
        step(1, 1, 0);
        repeat (299) step(1, 1, 0);
        step(1, 0, 0);
        period(5, 5, 20);
        period(5, 5, 20);
        repeat (3) step(1, 0, 0);
        check("lim_n", log_ctrl.size(), 3);
        check("lo_ctrl", log_ctrl[0], 3);
        check("lo_sat", log_sat[0], 1);
        check("hi_ctrl", log_ctrl[1], 252);
        check("hi_sat", log_sat[1], 1);
        check("nowrap_ctrl", log_ctrl[2], 131);
        check("nowrap_sat", log_sat[2], 0);

        // Reset mid-period, then enable toggling with an update in flight
        for (int i = 0; i < 6; i++) step(1'b1, i < 3, i < 1);
        do_reset();
        clear_log();
        period(6, 2, 20);
        check("post_rst_none", log_ctrl.size(), 0);
        period(6, 2, 20);
        repeat (3) step(1, 0, 0);
        check("en_upd", log_ctrl.size(), 1);
        check("en_upd_ctrl", log_ctrl[0], 144);
        repeat (4) step(0, 0, 0);
        check("en_hold", ctrl, 144);
        period(6, 2, 20);
        step(1, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        repeat (3) step(1, 0, 0);
        check("discard_n", log_ctrl.size(), 1);
        check("discard_ctrl", ctrl, 144);

        // Randomized pulse trains with enable drops and occasional resets
        ur = 0; dr = 0; uv = 0; dv = 0;
        for (int i = 0; i < 4000; i++) begin
            if (ur == 0) begin
                uv = !uv;
                ur = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 12);
            end
            ur--;
            if (dr == 0) begin
                dv = 1'($urandom_range(0, 1));
                dr = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 12);
            end
            dr--;
            ev = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 999) == 0) do_reset();
            step(ev, uv, dv);
        end

        // PWM duty: drive ctrl to 64 then measure one full PWM period
        do_reset();
        period(20, 4, 40);
        period(4, 20, 40);
        period(4, 4, 40);
        repeat (3) step(1, 0, 0);
        check("pwm_ctrl", ctrl, 64);
        repeat (520) step(0, 0, 0);
        high_cnt = 0;
        repeat (256) step(0, 0, 0);
        check("pwm_high", high_cnt, PWM_EXP);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
